// File: rtl/phase_delta_estimator.sv
// phase_delta_estimator
//   Recovers a DDFS frequency tuning word from a stream of phase samples.
//   The modulo-2^NBIT difference of consecutive samples is averaged over a
//   window of 2^LOG2_AVG deltas. The block reports the truncated mean and
//   whether every delta in the window was identical.
//
//   Optional feature macro: PDE_SPREAD_EN adds fw_spread (max-min delta).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   ph_valid   ph_in carries a new phase sample
//   ph_in      phase sample, unsigned, wraps at 2^NBIT
//   restart    synchronous re-prime; discards the partial window
//   fw_valid   single-cycle pulse when fw_out/fw_stable update
//   fw_out     estimated tuning word (held)
//   fw_stable  all deltas of the last window equal (held)
//   busy       reference sample held, window in progress
//   fw_spread  (PDE_SPREAD_EN only) max(delta)-min(delta) of last window
//
// state | meaning
// PRIME | waiting for a reference sample
// ACC   | accumulating deltas
module phase_delta_estimator #(
  parameter int NBIT     = 4,
  parameter int LOG2_AVG = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ph_valid,
  input  logic [NBIT-1:0] ph_in,
  input  logic            restart,
  output logic            fw_valid,
  output logic [NBIT-1:0] fw_out,
  output logic            fw_stable,
`ifdef PDE_SPREAD_EN
  output logic [NBIT-1:0] fw_spread,
`endif
  output logic            busy
);

  localparam int AW = NBIT + LOG2_AVG;
  // keep the counter at least one bit wide so LOG2_AVG=0 still elaborates
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic {PRIME, ACC} state_t;

  state_t          state_q, state_d;
  logic [NBIT-1:0] prev_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [NBIT-1:0] first_q;
  logic            eq_q;

  logic            accept, prime_ld, clear;
  logic [NBIT-1:0] delta;
  logic [AW-1:0]   acc_sum;
  logic            eq_all;
  logic            last;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    prime_ld = 1'b0;
    clear    = 1'b0;
    if (restart) begin
      clear    = 1'b1;
      prime_ld = ph_valid;
      state_d  = ph_valid ? ACC : PRIME;
    end else if (ph_valid) begin
      if (state_q == PRIME) begin
        prime_ld = 1'b1;
        clear    = 1'b1;
        state_d  = ACC;
      end else begin
        accept = 1'b1;
      end
    end
  end

  assign delta   = ph_in - prev_q;
  assign acc_sum = acc_q + AW'(delta);
  assign last    = accept && (cnt_q == CNT_LAST);
  // first delta of a window is trivially equal to itself
  assign eq_all  = (cnt_q == '0) || (eq_q && (delta == first_q));
  assign busy    = (state_q == ACC);

`ifdef PDE_SPREAD_EN
  logic [NBIT-1:0] max_q, min_q, max_n, min_n;
  always_comb begin
    max_n = delta;
    min_n = delta;
    if (cnt_q != '0) begin
      max_n = (delta > max_q) ? delta : max_q;
      min_n = (delta < min_q) ? delta : min_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q     <= '0;
      min_q     <= '0;
      fw_spread <= '0;
    end else if (accept) begin
      max_q <= max_n;
      min_q <= min_n;
      if (last) fw_spread <= max_n - min_n;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      first_q   <= '0;
      eq_q      <= 1'b1;
      fw_valid  <= 1'b0;
      fw_out    <= '0;
      fw_stable <= 1'b0;
    end else begin
      fw_valid <= 1'b0;
      if (prime_ld) prev_q <= ph_in;
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
        eq_q  <= 1'b1;
      end else if (accept) begin
        // prev always advances so consecutive windows share the boundary sample
        prev_q <= ph_in;
        if (last) begin
          fw_out    <= NBIT'(acc_sum >> LOG2_AVG);
          fw_stable <= eq_all;
          fw_valid  <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
          eq_q      <= 1'b1;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
          eq_q  <= eq_all;
          if (cnt_q == '0) first_q <= delta;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_delta_estimator.sv
module tb_phase_delta_estimator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ph_valid = 1'b0;
  logic [7:0] ph_in = 8'd0;
  logic       restart = 1'b0;

  logic       fw_valid, fw_stable, busy;
  logic [7:0] fw_out;
  logic       z_valid, z_stable, z_busy;
  logic [3:0] z_out;
`ifdef PDE_SPREAD_EN
  logic [7:0] fw_spread;
  logic [3:0] z_spread;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  phase_delta_estimator #(.NBIT(8), .LOG2_AVG(2)) dut (
    .clk(clk), .rst_n(rst_n), .ph_valid(ph_valid), .ph_in(ph_in),
    .restart(restart), .fw_valid(fw_valid), .fw_out(fw_out),
    .fw_stable(fw_stable),
`ifdef PDE_SPREAD_EN
    .fw_spread(fw_spread),
`endif
    .busy(busy));

  phase_delta_estimator #(.NBIT(4), .LOG2_AVG(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .ph_valid(ph_valid), .ph_in(ph_in[3:0]),
    .restart(restart), .fw_valid(z_valid), .fw_out(z_out),
    .fw_stable(z_stable),
`ifdef PDE_SPREAD_EN
    .fw_spread(z_spread),
`endif
    .busy(z_busy));

  typedef struct {
    logic       rst_n;
    logic       restart;
    logic       ph_valid;
    logic [7:0] ph_in;
    logic       e_valid;
    logic [7:0] e_out;
    logic       e_stable;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rs, input logic v, input logic [7:0] p,
                     input logic ev, input logic [7:0] eo, input logic es, input logic eb);
    vec_t t;
    t.rst_n = r; t.restart = rs; t.ph_valid = v; t.ph_in = p;
    t.e_valid = ev; t.e_out = eo; t.e_stable = es; t.e_busy = eb;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic rs, input logic v, input logic [7:0] p);
    @(negedge clk);
    rst_n = r; restart = rs; ph_valid = v; ph_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    add(0,0,0,8'd0,   0,8'd0,0,0);
    // constant step 0,5,10,15,20
    add(1,0,1,8'd0,   0,8'd0,0,1);
    add(1,0,1,8'd5,   0,8'd0,0,1);
    add(1,0,1,8'd10,  0,8'd0,0,1);
    add(1,0,1,8'd15,  0,8'd0,0,1);
    add(1,0,1,8'd20,  1,8'd5,1,1);
    add(1,0,0,8'd0,   0,8'd5,1,1);
    // back-to-back window, 20 is the shared reference
    add(1,0,1,8'd25,  0,8'd5,1,1);
    add(1,0,1,8'd30,  0,8'd5,1,1);
    add(1,0,1,8'd35,  0,8'd5,1,1);
    add(1,0,1,8'd40,  1,8'd5,1,1);
    // wrap-around
    add(1,1,0,8'd0,   0,8'd5,1,0);
    add(1,0,1,8'd250, 0,8'd5,1,1);
    add(1,0,1,8'd4,   0,8'd5,1,1);
    add(1,0,1,8'd14,  0,8'd5,1,1);
    add(1,0,1,8'd24,  0,8'd5,1,1);
    add(1,0,1,8'd34,  1,8'd10,1,1);
    // jitter
    add(1,1,0,8'd0,   0,8'd10,1,0);
    add(1,0,1,8'd0,   0,8'd10,1,1);
    add(1,0,1,8'd4,   0,8'd10,1,1);
    add(1,0,1,8'd9,   0,8'd10,1,1);
    add(1,0,1,8'd13,  0,8'd10,1,1);
    add(1,0,1,8'd18,  1,8'd4,0,1);
    // restart with a sample in the same cycle
    add(1,1,0,8'd0,   0,8'd4,0,0);
    add(1,0,1,8'd0,   0,8'd4,0,1);
    add(1,0,1,8'd7,   0,8'd4,0,1);
    add(1,0,1,8'd14,  0,8'd4,0,1);
    add(1,1,1,8'd100, 0,8'd4,0,1);
    add(1,0,1,8'd103, 0,8'd4,0,1);
    add(1,0,1,8'd106, 0,8'd4,0,1);
    add(1,0,1,8'd109, 0,8'd4,0,1);
    add(1,0,1,8'd112, 1,8'd3,1,1);
    // reset mid-window
    add(1,1,0,8'd0,   0,8'd3,1,0);
    add(1,0,1,8'd0,   0,8'd3,1,1);
    add(1,0,1,8'd6,   0,8'd3,1,1);
    add(1,0,1,8'd12,  0,8'd3,1,1);
    add(0,0,0,8'd0,   0,8'd0,0,0);
    add(1,0,1,8'd50,  0,8'd0,0,1);
    add(1,0,1,8'd56,  0,8'd0,0,1);
    add(1,0,1,8'd62,  0,8'd0,0,1);
    add(1,0,1,8'd68,  0,8'd0,0,1);
    add(1,0,1,8'd74,  1,8'd6,1,1);
    add(1,0,0,8'd0,   0,8'd6,1,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].restart, vecs[i].ph_valid, vecs[i].ph_in);
      check($sformatf("v%0d fw_valid", i), fw_valid, vecs[i].e_valid);
      check($sformatf("v%0d fw_out", i), fw_out, vecs[i].e_out);
      check($sformatf("v%0d fw_stable", i), fw_stable, vecs[i].e_stable);
      check($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
`ifdef PDE_SPREAD_EN
      // only the jitter window (deltas 4,5) has a non-zero spread
      check($sformatf("v%0d fw_spread", i), fw_spread, vecs[i].e_stable ? 0 : (vecs[i].e_out == 8'd4 ? 1 : 0));
`endif
    end

    // gapped valid: samples 0,5,10,15,20 with 1,3,0,2 idle cycles in between
    begin
      int gaps[4] = '{1, 3, 0, 2};
      int pulses = 0;
      drive(1, 1, 0, 8'd0);
      check("gap busy after restart", busy, 0);
      for (int k = 0; k < 5; k++) begin
        drive(1, 0, 1, 8'(k * 5));
        check($sformatf("gap busy s%0d", k), busy, 1);
        if (fw_valid) pulses++;
        if (k == 4) begin
          check("gap pulse after last", fw_valid, 1);
          check("gap fw_out", fw_out, 5);
          check("gap fw_stable", fw_stable, 1);
        end else begin
          for (int g = 0; g < gaps[k]; g++) begin
            drive(1, 0, 0, 8'd0);
            check($sformatf("gap busy idle s%0d", k), busy, 1);
            if (fw_valid) pulses++;
          end
        end
      end
      for (int g = 0; g < 3; g++) begin
        drive(1, 0, 0, 8'd0);
        if (fw_valid) pulses++;
      end
      check("gap pulse count", pulses, 1);
      check("gap fw_out held", fw_out, 5);
    end

    // LOG2_AVG=0 instance: every delta closes a window
    drive(1, 1, 0, 8'd0);
    drive(1, 0, 1, 8'd3);
    check("l0 prime no pulse", z_valid, 0);
    check("l0 busy", z_busy, 1);
    drive(1, 0, 1, 8'd7);
    check("l0 pulse 1", z_valid, 1);
    check("l0 out 1", z_out, 4);
    check("l0 stable 1", z_stable, 1);
    drive(1, 0, 1, 8'd2);
    check("l0 pulse 2", z_valid, 1);
    check("l0 out wrap", z_out, 11);
    check("l0 stable 2", z_stable, 1);
`ifdef PDE_SPREAD_EN
    check("l0 spread", z_spread, 0);
`endif
    drive(1, 0, 0, 8'd0);
    check("l0 idle no pulse", z_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
